hwpe_cfg_arbiter: RTL and testbench
===================================

# hwpe_cfg_arbiter

Round-robin arbiter and response router that sits directly upstream of the HWPE subsystem's configuration slave port. It merges the per-core peripheral configuration requests into the single HWPE config port and returns each single-cycle-latency response to the core that issued it. While the HWPE is disabled (clock-gated), it absorbs requests locally with an error pattern, so cores never stall on a dead accelerator.

## Interface
Parameters:
- N_CORES, 8, number of requesting cores (≥2)
- ID_WIDTH, 8, transaction id width
- ERR_DATA, 32'hBADC_AB1E, read data returned for locally absorbed requests

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- en_i  in  1  HWPE enabled; same signal that drives the HWPE clock gate
- core_req_i  in  N_CORES  per-core request
- core_add_i  in  N_CORES×32  address
- core_wen_i  in  N_CORES  1 = read, 0 = write
- core_be_i  in  N_CORES×4  byte enables
- core_wdata_i  in  N_CORES×32  write data
- core_id_i  in  N_CORES×ID_WIDTH  transaction id
- core_gnt_o  out  N_CORES  grant (one-hot or zero)
- core_r_valid_o  out  N_CORES  response valid (one-hot or zero)
- core_r_rdata_o  out  N_CORES×32  response data; value is the same on every lane
- core_r_id_o  out  N_CORES×ID_WIDTH  response id; value is the same on every lane
- cfg_req_o, cfg_add_o[31:0], cfg_wen_o, cfg_be_o[3:0], cfg_wdata_o[31:0], cfg_id_o[ID_WIDTH-1:0]  out  request to the HWPE config slave
- cfg_gnt_i  in  1  grant from the HWPE config slave
- cfg_r_valid_i  in  1  response valid, exactly 1 cycle after a granted request
- cfg_r_rdata_i  in  32  response data
- cfg_r_id_i  in  ID_WIDTH  response id (ignored for routing)
- drop_cnt_o  out  16  saturating count of locally absorbed requests plus spurious responses

## Operation
- Arbitration:
  - Winner is the first asserted core_req_i, scanning upward from rr_q with wrap-around.
  - The request mux is combinational, so cfg_* carry the winner's fields in the same cycle.
  - Non-winning cores see core_gnt_o = 0 and must hold their request.
- Enabled mode (en_i = 1):
  - cfg_req_o = any core_req_i.
  - core_gnt_o[winner] = cfg_gnt_i.
- Disabled mode (en_i = 0):
  - cfg_req_o = 0.
  - core_gnt_o[winner] = 1; the request is absorbed locally and writes are dropped.
  - drop_cnt_o increments.
- Handshake registration: on a handshake (a winner exists and its grant is asserted), the block registers:
  - rr_q ← (winner+1) mod N_CORES
  - idx_q ← winner
  - id_q ← core_id_i[winner]
  - local_q ← ~en_i
  - pend_q ← 1
  - In a cycle without a handshake, pend_q ← 0.
- Response cycle (pend_q = 1):
  - local_q = 0: core_r_valid_o[idx_q] = cfg_r_valid_i; rdata = cfg_r_rdata_i; r_id = cfg_r_id_i.
  - local_q = 1: core_r_valid_o[idx_q] = 1; rdata = ERR_DATA; r_id = id_q. Any concurrent cfg_r_valid_i is spurious.
- Spurious response: cfg_r_valid_i with pend_q = 0, or with local_q = 1. It is dropped (no core_r_valid_o) and drop_cnt_o increments.
- Counter: if a local absorb and a spurious response occur in the same cycle, drop_cnt_o increases by 2, saturating at 16'hFFFF.
- en_i toggling: the mode is sampled at handshake time. A response already pending is served per local_q, regardless of the current en_i.

## Timing
- Request path: combinational, core_req_i → cfg_req_o → cfg_gnt_i → core_gnt_o (0 register stages).
- Response latency: 1 cycle after grant, in both modes.
- Throughput: one transaction per cycle; a grant is allowed in the same cycle as the previous transaction's response.
- Reset state (synchronous, when rst = 1):
  - rr_q = 0, pend_q = 0, local_q = 0, idx_q = 0, id_q = 0, drop_cnt_o = 0.
  - All core_gnt_o and core_r_valid_o = 0; cfg_req_o = 0 while rst is asserted.
- Reset while a response is pending: the response is discarded and nothing is forwarded the following cycle.
- Single requester: that core wins every cycle; rr_q still advances past it.

## Test plan
- Single access: core 2 reads 0x0010 with en_i = 1 and slave gnt = 1 → core_gnt_o = 0x04 in cycle 0; next cycle core_r_valid_o = 0x04 with the slave's rdata 0x12345678.
- Fairness: all 4 cores of an N_CORES = 4 build hold req with gnt = 1 → grant order 0,1,2,3,0; responses route 1 cycle behind; no bubbles.
- Slave backpressure: cores 1 and 3 request, cfg_gnt_i = 0 for 3 cycles then 1 → no core_gnt_o for 3 cycles, then core 1 is granted; rr_q advances only on the handshake.
- Disabled mode: en_i = 0, core 0 writes and then reads → cfg_req_o stays 0; both are granted immediately; the read returns 0xBADCAB1E with its id; drop_cnt_o = 2.
- Mode switch and spurious response: grant with en_i = 1, drop en_i in the response cycle → slave data is still routed. Then inject cfg_r_valid_i with no pending transaction → no core_r_valid_o and drop_cnt_o +1. Force drop_cnt_o to 0xFFFF → it stays 0xFFFF.
- Reset mid-operation: assert rst in the cycle after a grant → no core_r_valid_o; after release, rr_q = 0 and core 0 wins first.

Source files
------------

// File: rtl/hwpe_cfg_arbiter_if.sv
// Bus bundle between the per-core config masters and the HWPE config slave.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface hwpe_cfg_arbiter_if #(
  parameter int N_CORES  = 8,
  parameter int ID_WIDTH = 8
);
  logic [N_CORES-1:0]               core_req_i;
  logic [N_CORES-1:0][31:0]         core_add_i;
  logic [N_CORES-1:0]               core_wen_i;
  logic [N_CORES-1:0][3:0]          core_be_i;
  logic [N_CORES-1:0][31:0]         core_wdata_i;
  logic [N_CORES-1:0][ID_WIDTH-1:0] core_id_i;
  logic [N_CORES-1:0]               core_gnt_o;
  logic [N_CORES-1:0]               core_r_valid_o;
  logic [N_CORES-1:0][31:0]         core_r_rdata_o;
  logic [N_CORES-1:0][ID_WIDTH-1:0] core_r_id_o;

  logic                cfg_req_o;
  logic [31:0]         cfg_add_o;
  logic                cfg_wen_o;
  logic [3:0]          cfg_be_o;
  logic [31:0]         cfg_wdata_o;
  logic [ID_WIDTH-1:0] cfg_id_o;
  logic                cfg_gnt_i;
  logic                cfg_r_valid_i;
  logic [31:0]         cfg_r_rdata_i;
  logic [ID_WIDTH-1:0] cfg_r_id_i;

  modport slave (
    input  core_req_i, core_add_i, core_wen_i, core_be_i, core_wdata_i, core_id_i,
    output core_gnt_o, core_r_valid_o, core_r_rdata_o, core_r_id_o,
    output cfg_req_o, cfg_add_o, cfg_wen_o, cfg_be_o, cfg_wdata_o, cfg_id_o,
    input  cfg_gnt_i, cfg_r_valid_i, cfg_r_rdata_i, cfg_r_id_i
  );

  modport master (
    output core_req_i, core_add_i, core_wen_i, core_be_i, core_wdata_i, core_id_i,
    input  core_gnt_o, core_r_valid_o, core_r_rdata_o, core_r_id_o,
    input  cfg_req_o, cfg_add_o, cfg_wen_o, cfg_be_o, cfg_wdata_o, cfg_id_o,
    output cfg_gnt_i, cfg_r_valid_i, cfg_r_rdata_i, cfg_r_id_i
  );
endinterface

// File: rtl/hwpe_cfg_arbiter.sv
// Round-robin merge of per-core config requests onto the HWPE config port, with
// 1-cycle response routing and local error absorption while the HWPE is gated off.
module hwpe_cfg_arbiter #(
  parameter int          N_CORES  = 8,
  parameter int          ID_WIDTH = 8,
  parameter logic [31:0] ERR_DATA = 32'hBADC_AB1E
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  hwpe_cfg_arbiter_if.slave   bus,
  output logic [15:0]         drop_cnt_o
);

  localparam int                 IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [IDX_W:0]     NC    = (IDX_W+1)'(N_CORES);
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(N_CORES - 1);
  localparam logic [N_CORES-1:0] LANE0 = N_CORES'(1);

  logic [IDX_W-1:0]    r_rr;
  logic [IDX_W-1:0]    r_idx;
  logic [ID_WIDTH-1:0] r_id;
  logic                r_local;
  logic                r_pend;
  logic [15:0]         r_drop;

  logic [2*N_CORES-1:0] w_req_dbl;
  logic [N_CORES-1:0]   w_req_rot;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W:0]       w_wrap;
  logic [IDX_W-1:0]     w_winner;
  logic [IDX_W-1:0]     w_rr_nxt;
  logic                 w_found;
  logic                 w_hs;
  logic                 w_absorb;
  logic                 w_spur;
  logic                 w_resp;
  logic [1:0]           w_inc;
  logic [16:0]          w_cnt_sum;
  logic [31:0]          w_rdata;
  logic [ID_WIDTH-1:0]  w_rid;

  // Rotate so that position 0 is the round-robin pointer; the lowest set bit is the winner.
  assign w_req_dbl = {bus.core_req_i, bus.core_req_i} >> r_rr;
  assign w_req_rot = w_req_dbl[N_CORES-1:0];
  assign w_found   = |bus.core_req_i;

  always_comb begin
    w_off = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign w_sum    = {1'b0, r_rr} + {1'b0, w_off};
  assign w_wrap   = (w_sum >= NC) ? (w_sum - NC) : w_sum;
  assign w_winner = w_wrap[IDX_W-1:0];
  assign w_rr_nxt = (w_winner == LAST) ? '0 : (w_winner + 1'b1);

  // A gated HWPE cannot answer, so the arbiter grants on its behalf.
  assign w_hs     = ~rst & w_found & (en_i ? bus.cfg_gnt_i : 1'b1);
  assign w_absorb = w_hs & ~en_i;

  assign bus.cfg_req_o   = ~rst & en_i & w_found;
  assign bus.cfg_add_o   = bus.core_add_i[w_winner];
  assign bus.cfg_wen_o   = bus.core_wen_i[w_winner];
  assign bus.cfg_be_o    = bus.core_be_i[w_winner];
  assign bus.cfg_wdata_o = bus.core_wdata_i[w_winner];
  assign bus.cfg_id_o    = bus.core_id_i[w_winner];
  assign bus.core_gnt_o  = w_hs ? (LANE0 << w_winner) : '0;

  assign w_resp = ~rst & r_pend & (r_local | bus.cfg_r_valid_i);
  assign w_spur = ~rst & bus.cfg_r_valid_i & (~r_pend | r_local);

  assign bus.core_r_valid_o = w_resp ? (LANE0 << r_idx) : '0;
  assign w_rdata = r_local ? ERR_DATA : bus.cfg_r_rdata_i;
  assign w_rid   = r_local ? r_id : bus.cfg_r_id_i;

  always_comb begin
    bus.core_r_rdata_o = '0;
    bus.core_r_id_o    = '0;
    for (int c = 0; c < N_CORES; c++) begin
      bus.core_r_rdata_o[c] = w_rdata;
      bus.core_r_id_o[c]    = w_rid;
    end
  end

  assign w_inc     = {1'b0, w_absorb} + {1'b0, w_spur};
  assign w_cnt_sum = {1'b0, r_drop} + {15'd0, w_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr    <= '0;
      r_idx   <= '0;
      r_id    <= '0;
      r_local <= 1'b0;
      r_pend  <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (w_hs) begin
        r_rr    <= w_rr_nxt;
        r_idx   <= w_winner;
        r_id    <= bus.core_id_i[w_winner];
        r_local <= ~en_i;
        r_pend  <= 1'b1;
      end else begin
        r_pend  <= 1'b0;
      end
      r_drop <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign drop_cnt_o = r_drop;

endmodule

// File: tb/tb_hwpe_cfg_arbiter.sv
// Directed and randomized checks of hwpe_cfg_arbiter against a transaction-level model.
module tb_hwpe_cfg_arbiter;
  localparam int          N   = 4;
  localparam int          IW  = 8;
  localparam logic [31:0] ERR = 32'hBADCAB1E;

  logic        clk = 1'b0;
  logic [15:0] drop_cnt_o;
  always #5 clk = ~clk;

  logic                 t_rst, t_en, t_gnt, t_rv;
  logic [31:0]          t_rdata;
  logic [IW-1:0]        t_rid;
  logic [N-1:0]         t_req, t_wen;
  logic [N-1:0][31:0]   t_add, t_wdata;
  logic [N-1:0][3:0]    t_be;
  logic [N-1:0][IW-1:0] t_id;

  hwpe_cfg_arbiter_if #(.N_CORES(N), .ID_WIDTH(IW)) bus ();

  hwpe_cfg_arbiter #(.N_CORES(N), .ID_WIDTH(IW), .ERR_DATA(ERR)) dut (
    .clk        (clk),
    .rst        (t_rst),
    .en_i       (t_en),
    .bus        (bus.slave),
    .drop_cnt_o (drop_cnt_o)
  );

  assign bus.core_req_i    = t_req;
  assign bus.core_add_i    = t_add;
  assign bus.core_wen_i    = t_wen;
  assign bus.core_be_i     = t_be;
  assign bus.core_wdata_i  = t_wdata;
  assign bus.core_id_i     = t_id;
  assign bus.cfg_gnt_i     = t_gnt;
  assign bus.cfg_r_valid_i = t_rv;
  assign bus.cfg_r_rdata_i = t_rdata;
  assign bus.cfg_r_id_i    = t_rid;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int            m_rr, m_idx, m_drop;
  bit            m_pend, m_local;
  logic [IW-1:0] m_id;

  logic [N-1:0]  obs_gnt, obs_rv;
  logic          obs_cfg_req;
  logic [31:0]   obs_rdata;
  logic [IW-1:0] obs_rid;
  logic [15:0]   obs_drop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int rr);
    int best  = -1;
    int bestd = N;
    for (int c = 0; c < N; c++) begin
      if (req[c]) begin
        int d = (c - rr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  task automatic set_in(input logic r, input logic e, input logic [N-1:0] req, input logic g,
                        input logic rv, input logic [31:0] rd, input logic [IW-1:0] rid);
    t_rst = r; t_en = e; t_req = req; t_gnt = g; t_rv = rv; t_rdata = rd; t_rid = rid;
    for (int c = 0; c < N; c++) begin
      t_add[c]   = $urandom;
      t_wdata[c] = $urandom;
      t_be[c]    = 4'($urandom);
      t_wen[c]   = 1'($urandom);
      t_id[c]    = IW'($urandom);
    end
  endtask

  task automatic step();
    int           w;
    logic [N-1:0] e_gnt, e_rv;
    bit           hs, spur, absorb;
    @(negedge clk);
    w     = pick(t_req, m_rr);
    e_gnt = (!t_rst && w >= 0 && (t_en ? t_gnt : 1'b1)) ? (N'(1) << w) : '0;
    hs    = (e_gnt != '0);
    e_rv  = (!t_rst && m_pend && (m_local || t_rv)) ? (N'(1) << m_idx) : '0;
    obs_gnt     = bus.core_gnt_o;
    obs_rv      = bus.core_r_valid_o;
    obs_cfg_req = bus.cfg_req_o;
    obs_rdata   = bus.core_r_rdata_o[0];
    obs_rid     = bus.core_r_id_o[0];
    obs_drop    = drop_cnt_o;
    check("cfg_req", 64'(bus.cfg_req_o), 64'(!t_rst && t_en && w >= 0));
    check("core_gnt", 64'(bus.core_gnt_o), 64'(e_gnt));
    check("core_r_valid", 64'(bus.core_r_valid_o), 64'(e_rv));
    check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
    if (w >= 0 && !t_rst && t_en) begin
      check("cfg_add", 64'(bus.cfg_add_o), 64'(t_add[w]));
      check("cfg_wdata", 64'(bus.cfg_wdata_o), 64'(t_wdata[w]));
      check("cfg_ctl", 64'({bus.cfg_wen_o, bus.cfg_be_o, bus.cfg_id_o}),
            64'({t_wen[w], t_be[w], t_id[w]}));
    end
    if (e_rv != '0) begin
      check("r_rdata_lane0", 64'(bus.core_r_rdata_o[0]), 64'(m_local ? ERR : t_rdata));
      check("r_rdata_lastlane", 64'(bus.core_r_rdata_o[N-1]), 64'(m_local ? ERR : t_rdata));
      check("r_id_lastlane", 64'(bus.core_r_id_o[N-1]), 64'(m_local ? m_id : t_rid));
    end
    @(posedge clk);
    if (t_rst) begin
      m_rr = 0; m_idx = 0; m_id = '0; m_local = 0; m_pend = 0; m_drop = 0;
    end else begin
      spur   = t_rv && (!m_pend || m_local);
      absorb = hs && !t_en;
      m_drop = m_drop + int'(spur) + int'(absorb);
      if (m_drop > 65535) m_drop = 65535;
      if (hs) begin
        m_rr = (w + 1) % N; m_idx = w; m_id = t_id[w]; m_local = !t_en; m_pend = 1;
      end else begin
        m_pend = 0;
      end
    end
    #1;
  endtask

  initial begin
    m_rr = 0; m_idx = 0; m_id = '0; m_local = 0; m_pend = 0; m_drop = 0;
    set_in(1, 1, '0, 0, 0, '0, '0);
    #1;
    step(); step();
    check("rst_gnt", 64'(obs_gnt), 64'h0);
    check("rst_drop", 64'(obs_drop), 64'h0);

    // single access by core 2
    set_in(0, 1, 4'b0100, 1, 0, '0, '0);
    t_add[2] = 32'h0000_0010; t_wen[2] = 1'b1;
    step();
    check("single_gnt", 64'(obs_gnt), 64'h4);
    set_in(0, 1, '0, 1, 1, 32'h1234_5678, 8'h22);
    step();
    check("single_rv", 64'(obs_rv), 64'h4);
    check("single_rdata", 64'(obs_rdata), 64'h1234_5678);

    // fairness from a fresh pointer
    set_in(1, 1, '0, 0, 0, '0, '0);
    step();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 4'hF, 1, (i > 0), $urandom, IW'($urandom));
      step();
      check("fair_gnt", 64'(obs_gnt), 64'(N'(1) << (i % N)));
      if (i > 0) check("fair_rv", 64'(obs_rv), 64'(N'(1) << ((i - 1) % N)));
    end

    // slave backpressure
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 4'b1010, 0, (i == 0), $urandom, IW'($urandom));
      step();
      check("bp_stall_gnt", 64'(obs_gnt), 64'h0);
    end
    set_in(0, 1, 4'b1010, 1, 0, '0, '0);
    step();
    check("bp_gnt", 64'(obs_gnt), 64'h2);
    set_in(0, 1, '0, 0, 1, 32'h0BAD_F00D, 8'h11);
    step();

    // disabled mode: write then read by core 0
    set_in(0, 0, 4'b0001, 0, 0, '0, '0);
    t_wen[0] = 1'b0;
    step();
    check("dis_cfg_req", 64'(obs_cfg_req), 64'h0);
    check("dis_wr_gnt", 64'(obs_gnt), 64'h1);
    set_in(0, 0, 4'b0001, 0, 0, '0, '0);
    t_wen[0] = 1'b1; t_id[0] = 8'h5A;
    step();
    check("dis_rd_gnt", 64'(obs_gnt), 64'h1);
    set_in(0, 0, '0, 0, 0, '0, '0);
    step();
    check("dis_rdata", 64'(obs_rdata), 64'(ERR));
    check("dis_rid", 64'(obs_rid), 64'h5A);
    check("dis_drop", 64'(obs_drop), 64'h2);

    // mode switch while the response is pending, then a spurious response
    set_in(0, 1, 4'b0001, 1, 0, '0, '0);
    step();
    set_in(0, 0, '0, 0, 1, 32'hCAFE_F00D, 8'h33);
    step();
    check("switch_rv", 64'(obs_rv), 64'h1);
    check("switch_rdata", 64'(obs_rdata), 64'hCAFE_F00D);
    set_in(0, 0, '0, 0, 1, 32'h1111_1111, 8'h44);
    step();
    check("spur_rv", 64'(obs_rv), 64'h0);
    set_in(0, 0, '0, 0, 0, '0, '0);
    step();
    check("spur_drop", 64'(obs_drop), 64'h3);

    // reset in the response cycle
    set_in(0, 1, 4'b0100, 1, 0, '0, '0);
    step();
    set_in(1, 1, 4'hF, 1, 1, 32'h5555_5555, 8'h55);
    step();
    check("rstmid_rv", 64'(obs_rv), 64'h0);
    set_in(0, 1, 4'hF, 1, 0, '0, '0);
    step();
    check("rstmid_rv_after", 64'(obs_rv), 64'h0);
    check("rstmid_gnt", 64'(obs_gnt), 64'h1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rv;
      if (m_pend && !m_local) rv = ($urandom_range(0, 7) != 0);
      else                    rv = ($urandom_range(0, 7) == 0);
      set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), N'($urandom),
             1'($urandom), rv, $urandom, IW'($urandom));
      step();
    end

    // saturation: two drops per cycle until the counter pins
    set_in(1, 0, '0, 0, 0, '0, '0);
    step();
    for (int i = 0; i < 32800; i++) begin
      set_in(0, 0, 4'hF, 0, 1, $urandom, IW'($urandom));
      step();
    end
    check("sat_drop", 64'(obs_drop), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
